// File: rtl/sync_fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and requester bound.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package sync_fifo_arb_pkg;

  localparam int NUM_REQ_MAX = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sync_fifo_wr_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  localparam logic [IW:0] N_W = (IW+1)'(NUM_REQ);

  logic [IW:0]   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      cand_idx = cand[IW-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Packet-locked round-robin arbiter in front of a sync_fifo write port, with stall timeout.
module sync_fifo_wr_arb
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int STALL_LIMIT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid_s,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_datain,
  input  logic [NUM_REQ-1:0]            i_last_s,
  output logic [NUM_REQ-1:0]            o_ready_s,
  output logic                          o_valid_m,
  output logic [DATA_WIDTH-1:0]         o_dataout,
  input  logic                          i_ready_m,
  input  logic                          i_almostfull,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] STALL_HIT = CW'(STALL_LIMIT - 1);

  arb_state_t    state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] next_ptr;
  logic [CW-1:0] stall_cnt;
  logic          arb_found;
  logic          lock;
  logic          cur_valid;
  logic          xfer;
  logic          stall_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req   (i_valid_s),
    .ptr   (rr_ptr),
    .found (arb_found),
    .idx   (arb_idx)
  );

  // Handshake: a beat moves on a cycle where valid and ready are both high; valid
  // never waits on ready. Only the granted requester sees ready, and it is held
  // low while reset is asserted so nothing is written on the reset edge.
  assign lock      = (state == LOCK) && !i_rst;
  assign cur_valid = i_valid_s[gidx];
  assign o_valid_m = lock && cur_valid;
  assign o_dataout = i_datain[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign xfer      = o_valid_m && i_ready_m;
  assign o_busy    = (state == LOCK);

  always_comb begin
    o_ready_s = '0;
    if (lock) o_ready_s[gidx] = i_ready_m;
  end

  // Only an absent beat counts as a stall; backpressure from the FIFO does not.
  assign stall_hit = lock && !cur_valid && (stall_cnt == STALL_HIT);
  assign next_ptr  = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      gidx      <= '0;
      rr_ptr    <= '0;
      o_grant   <= '0;
      stall_cnt <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found && !i_almostfull) begin
            state     <= LOCK;
            gidx      <= arb_idx;
            o_grant   <= NUM_REQ'(1) << arb_idx;
            stall_cnt <= '0;
          end
        end
        LOCK: begin
          if (xfer && i_last_s[gidx]) begin
            state     <= IDLE;
            o_grant   <= '0;
            rr_ptr    <= next_ptr;
            stall_cnt <= '0;
          end else if (stall_hit) begin
            state     <= IDLE;
            o_grant   <= '0;
            rr_ptr    <= next_ptr;
            stall_cnt <= '0;
            o_timeout <= 1'b1;
          end else if (xfer) begin
            stall_cnt <= '0;
          end else if (!cur_valid) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb: requester queues drive beats, a FIFO-side scoreboard checks order.
module tb_sync_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int SL   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] i_valid_s;
  logic [NREQ-1:0] i_last_s;
  logic [NREQ*W-1:0] i_datain;
  logic [NREQ-1:0] o_ready_s;
  logic            o_valid_m;
  logic [W-1:0]    o_dataout;
  logic            i_ready_m;
  logic            i_almostfull;
  logic [NREQ-1:0] o_grant;
  logic            o_busy;
  logic            o_timeout;

  sync_fifo_wr_arb #(.NUM_REQ(NREQ), .DATA_WIDTH(W), .STALL_LIMIT(SL)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid_s    (i_valid_s),
    .i_datain     (i_datain),
    .i_last_s     (i_last_s),
    .o_ready_s    (o_ready_s),
    .o_valid_m    (o_valid_m),
    .o_dataout    (o_dataout),
    .i_ready_m    (i_ready_m),
    .i_almostfull (i_almostfull),
    .o_grant      (o_grant),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W:0]      src_q [NREQ][$];
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    got_q[$];
  int              got_cyc[$];
  int              xc[$];
  logic [NREQ-1:0] fire = '0;
  logic            cap_busy = 1'b0;
  logic            cap_to = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input int k, input int s);
    logic [1:0] kk;
    logic [5:0] ss;
    kk = k[1:0];
    ss = s[5:0];
    return {kk, ss};
  endfunction

  // driver tasks
  task automatic send_pkt(input int k, input int len, input int s0, input bit with_last);
    logic lst;
    for (int i = 0; i < len; i++) begin
      lst = with_last && (i == len - 1);
      src_q[k].push_back({lst, mk(k, s0 + i)});
    end
  endtask

  // Capture at the falling edge (what the next rising edge will write), then drive after the edge.
  task automatic step();
    logic [W:0] head;
    @(negedge clk);
    cyc++;
    fire     = i_valid_s & o_ready_s;
    cap_busy = o_busy;
    cap_to   = o_timeout;
    if (o_valid_m && i_ready_m) begin
      got_q.push_back(o_dataout);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      head = '0;
      if (src_q[k].size() > 0) head = src_q[k][0];
      i_valid_s[k]         = (src_q[k].size() > 0);
      i_last_s[k]          = head[W];
      i_datain[k*W +: W]   = head[W-1:0];
    end
  endtask

  // scoreboard: compare beats written to the FIFO against the expected queue
  task automatic drain(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (got_q.size() < n && b < budget) begin
      step();
      b++;
    end
    check_eq({tag, "_count"}, got_q.size(), n);
    xc.delete();
    for (int i = 0; i < n; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      check_eq({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
      xc.push_back(got_cyc.pop_front());
    end
  endtask

  function automatic int xc_at(input int i);
    if (xc.size() > i) return xc[i];
    return -1000;
  endfunction

  int n_to;
  int n_busy;
  int to_cyc;
  int b;

  initial begin
    rst          = 1'b1;
    i_valid_s    = '0;
    i_last_s     = '0;
    i_datain     = '0;
    i_ready_m    = 1'b1;
    i_almostfull = 1'b0;
    step();
    step();
    check_eq("rst_grant", o_grant, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_valid_m", o_valid_m, 0);
    check_eq("rst_ready_s", o_ready_s, 0);
    check_eq("rst_timeout", o_timeout, 0);
    rst = 1'b0;

    // single-beat packets from all requesters: order 0,1,2,3,0,1,2,3, one beat per 2 cycles
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NREQ; k++) begin
        send_pkt(k, 1, r, 1'b1);
        exp_q.push_back(mk(k, r));
      end
    drain("rr", 8, 40);
    for (int i = 0; i < 7; i++) check_eq("rr_gap", xc_at(i + 1) - xc_at(i), 2);
    step();
    step();

    // 5-beat packet from 2 holds the port while 0 waits
    send_pkt(2, 5, 8, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(2, 8 + i));
    exp_q.push_back(mk(0, 16));
    step();
    step();
    send_pkt(0, 1, 16, 1'b1);
    step();
    check_eq("lock_grant", o_grant, 4'b0100);
    check_eq("lock_ready_s", o_ready_s, 4'b0100);
    drain("pkt", 6, 30);
    for (int i = 0; i < 4; i++) check_eq("pkt_contig", xc_at(i + 1) - xc_at(i), 1);
    check_eq("pkt_next_grant", xc_at(5) - xc_at(4), 2);
    step();

    // almost-full blocks new grants but not a packet in flight
    i_almostfull = 1'b1;
    send_pkt(1, 1, 20, 1'b1);
    for (int i = 0; i < 6; i++) step();
    check_eq("af_grant", o_grant, 0);
    check_eq("af_busy", o_busy, 0);
    check_eq("af_no_beat", got_q.size(), 0);
    i_almostfull = 1'b0;
    exp_q.push_back(mk(1, 20));
    drain("af_release", 1, 10);
    step();
    send_pkt(3, 4, 24, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3, 24 + i));
    b = 0;
    while (!o_busy && b < 10) begin
      step();
      b++;
    end
    check_eq("af_lock", o_busy, 1);
    i_almostfull = 1'b1;
    drain("af_mid", 4, 20);
    i_almostfull = 1'b0;
    step();

    // requester 3 goes silent mid-packet: timeout after SL idle cycles
    send_pkt(3, 2, 32, 1'b0);
    exp_q.push_back(mk(3, 32));
    exp_q.push_back(mk(3, 33));
    drain("stall_beats", 2, 10);
    n_to   = 0;
    n_busy = 0;
    to_cyc = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (cap_to) begin
        n_to++;
        to_cyc = cyc;
        check_eq("to_busy_low", cap_busy, 0);
      end else if (cap_busy) begin
        n_busy++;
      end
    end
    check_eq("to_pulses", n_to, 1);
    check_eq("to_delay", to_cyc - xc_at(1), SL + 1);
    check_eq("to_stall_cycles", n_busy, SL);
    send_pkt(1, 1, 40, 1'b1);
    send_pkt(3, 1, 41, 1'b1);
    exp_q.push_back(mk(1, 40));
    exp_q.push_back(mk(3, 41));
    drain("to_next", 2, 20);
    step();

    // FIFO backpressure mid-packet is not a stall
    send_pkt(0, 6, 48, 1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(0, 48 + i));
    drain("bp_head", 2, 10);
    i_ready_m = 1'b0;
    n_to   = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cap_to) n_to++;
      if (cap_busy) n_busy++;
    end
    check_eq("bp_no_timeout", n_to, 0);
    check_eq("bp_busy", n_busy, 40);
    check_eq("bp_no_xfer", got_q.size(), 0);
    i_ready_m = 1'b1;
    drain("bp_resume", 4, 20);
    step();

    // reset on beat 3 of an 8-beat packet: grant dropped, pointer back to 0
    send_pkt(2, 8, 56, 1'b1);
    exp_q.push_back(mk(2, 56));
    exp_q.push_back(mk(2, 57));
    drain("rmid_head", 2, 10);
    rst = 1'b1;
    src_q[2].delete();
    step();
    check_eq("rmid_grant", o_grant, 0);
    check_eq("rmid_busy", o_busy, 0);
    check_eq("rmid_valid_m", o_valid_m, 0);
    check_eq("rmid_rr_ptr", dut.rr_ptr, 0);
    rst = 1'b0;
    send_pkt(1, 1, 60, 1'b1);
    send_pkt(0, 1, 61, 1'b1);
    exp_q.push_back(mk(0, 61));
    exp_q.push_back(mk(1, 60));
    drain("rmid_next", 2, 20);
    step();
    step();
    check_eq("sb_extra_beats", got_q.size(), 0);
    check_eq("sb_missing_beats", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/sync_fifo_wr_arb.md
SYNC_FIFO_WR_ARB -- requirements
Module: sync_fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH, beat width, identical to the attached sync_fifo.
REQ-003 Parameter STALL_LIMIT, default 16, idle cycles inside a packet before the grant is forcibly released (>=1).
REQ-004 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port i_rst  input  1  reset, synchronous, active-high.
REQ-006 Port i_valid_s  input  NUM_REQ  per-requester beat valid.
REQ-007 Port i_datain  input  NUM_REQ*DATA_WIDTH  packed beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port i_last_s  input  NUM_REQ  per-requester last-beat-of-packet marker, qualified by i_valid_s.
REQ-009 Port o_ready_s  output  NUM_REQ  per-requester beat accepted when high together with i_valid_s.
REQ-010 Port o_valid_m  output  1  beat valid toward the FIFO write port (drives FIFO i_valid_s).
REQ-011 Port o_dataout  output  DATA_WIDTH  beat toward the FIFO (drives FIFO i_datain).
REQ-012 Port i_ready_m  input  1  FIFO can accept a write (from FIFO o_ready_s).
REQ-013 Port i_almostfull  input  1  FIFO almost-full flag (from FIFO o_almostfull).
REQ-014 Port o_grant  output  NUM_REQ  registered one-hot grant; all-zero when no grant is held.
REQ-015 Port o_busy  output  1  high while a packet grant is held.
REQ-016 Port o_timeout  output  1  one-cycle pulse when a grant is released by stall timeout.

Function
REQ-017 FSM states: IDLE (no grant, no transfers) and LOCK (one requester owns the FIFO write port).
REQ-018 IDLE->LOCK when any i_valid_s bit is high and i_almostfull is low; the grant is registered, so the first beat transfers no earlier than the cycle after the request is first seen.
REQ-019 Winner selection is round-robin: the first requester with i_valid_s high, searching upward from rr_ptr with wrap from NUM_REQ-1 to 0.
REQ-020 In IDLE with i_almostfull high, no grant is issued; requests wait without loss.
REQ-021 In LOCK with grant g: o_valid_m = i_valid_s[g]; o_dataout = beat g; o_ready_s[g] = i_ready_m; all other o_ready_s bits are 0.
REQ-022 In IDLE: o_valid_m = 0 and o_ready_s = 0; o_dataout is don't-care.
REQ-023 A beat transfers when o_valid_m and i_ready_m are both high; i_almostfull does not block beats inside a held packet.
REQ-024 A transfer with i_last_s[g] high: LOCK->IDLE on the next edge, and rr_ptr becomes (g+1) mod NUM_REQ.
REQ-025 A single-beat packet (valid and last on its first beat) holds LOCK for exactly one cycle.
REQ-026 Stall counter: cleared on grant and on every transfer; increments each LOCK cycle in which i_valid_s[g] is low. A stall caused by i_ready_m low does not count.
REQ-027 Stall counter reaching STALL_LIMIT: LOCK->IDLE, o_timeout pulses for one cycle, and rr_ptr becomes (g+1) mod NUM_REQ.
REQ-028 o_grant and o_busy change only on clock edges; o_busy = (state == LOCK).
REQ-029 The counter is sized $clog2(STALL_LIMIT+1) bits and rr_ptr $clog2(NUM_REQ) bits; neither wraps.

Reset
REQ-030 Reset while i_rst is high at a rising edge: state IDLE, rr_ptr 0, o_grant 0, stall counter 0, o_timeout 0.
REQ-031 During and after reset, o_busy, o_valid_m and o_ready_s are 0.
REQ-032 Reset mid-packet drops the grant immediately; the partial packet is not completed, and the FIFO keeps already-written beats.

Structure
REQ-033 Package sync_fifo_arb_pkg holds the FSM state typedef (IDLE, LOCK) and the constant NUM_REQ_MAX = 8.
REQ-034 A single sub-module, rr_arbiter (combinational round-robin priority pick from request vector and rr_ptr), is natural; the FSM, counter and mux stay in sync_fifo_wr_arb.

Verification
REQ-035 Requesters 0..3 all send 1-beat packets continuously with i_ready_m=1 -> grant order 0,1,2,3,0; one transfer every 2 cycles.
REQ-036 Requester 2 sends a 5-beat packet while requester 0 requests -> all 5 beats of 2 are contiguous in the FIFO; requester 0 is granted the cycle after 2's last beat.
REQ-037 i_almostfull=1 in IDLE with requester 1 valid -> no grant; i_almostfull=1 raised mid-packet -> the packet completes.
REQ-038 Requester 3 locked, then i_valid_s[3]=0 for 16 cycles -> o_timeout pulses once, o_busy falls, and the next grant searches from requester 0.
REQ-039 i_ready_m=0 for 40 cycles mid-packet -> no timeout; beats resume unchanged when i_ready_m returns to 1.
REQ-040 i_rst asserted on beat 3 of an 8-beat packet -> next cycle o_grant=0, o_busy=0, rr_ptr=0; a scoreboard against sync_fifo o_dataout confirms no beat is duplicated or reordered.
